// File: rtl/ram64_fifo_pkg.sv
// ram64_fifo_pkg
// Shared sizing and types for the 64-deep distributed-RAM FIFO controller.
//   FIFO_DEPTH : number of words held by the 64x1 RAM bank
//   PTR_W      : RAM address width (A5..A0 / DPRA5..DPRA0)
//   CNT_W      : occupancy width, holds 0..64
package ram64_fifo_pkg;
   localparam int FIFO_DEPTH = 64;
   localparam int PTR_W      = 6;
   localparam int CNT_W      = 7;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/ram64_fifo_ptr.sv
// ram64_fifo_ptr
// 6-bit wrapping RAM address pointer; used once for the write side and once
// for the read side of the FIFO.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset, pointer returns to 0
//   inc_i  : advance pointer by one (63 wraps to 0)
//   ptr_o  : registered pointer value
module ram64_fifo_ptr
   import ram64_fifo_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   output ptr_t ptr_o
);

   ptr_t ptr_q, ptr_d;

   // Natural 6-bit overflow provides the mod-64 wrap.
   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) ptr_d = ptr_q + ptr_t'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/ram64_fifo_ctrl.sv
// ram64_fifo_ctrl
// Rising-edge controller that turns a bank of WIDTH 64x1 dual-port
// distributed RAMs (falling-edge write, asynchronous read) into a 64-deep
// first-word-fall-through FIFO. The RAM bank lives in the parent.
//   CLK, RST          : clock (rising edge) and synchronous active-high reset
//   WR_EN, DIN        : push request and data
//   RD_EN             : pop request, consumes the word on DOUT
//   DOUT              : head of FIFO, straight from RAM_DPO
//   FULL, EMPTY, COUNT: occupancy status, decoded from the registered count
//   OVERFLOW/UNDERFLOW: sticky rejected-push / rejected-pop flags
//   RAM_A, RAM_DPRA   : write / read pointers to the RAM bank
//   RAM_WE, RAM_D     : RAM write strobe and data (combinational)
//   RAM_DPO           : RAM dual-port read data
//   ALMOST_FULL/EMPTY : registered thresholds, only built when the macro
//                       RAM64_FIFO_ALMOST_EN is defined; constant 0 otherwise
module ram64_fifo_ctrl
   import ram64_fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 48,
   parameter int AE_LEVEL = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WR_EN,
   input  logic [WIDTH-1:0] DIN,
   input  logic             RD_EN,
   output logic [WIDTH-1:0] DOUT,
   output logic             FULL,
   output logic             EMPTY,
   output logic [6:0]       COUNT,
   output logic             OVERFLOW,
   output logic             UNDERFLOW,
   output logic [5:0]       RAM_A,
   output logic [5:0]       RAM_DPRA,
   output logic             RAM_WE,
   output logic [WIDTH-1:0] RAM_D,
   input  logic [WIDTH-1:0] RAM_DPO,
   output logic             ALMOST_FULL,
   output logic             ALMOST_EMPTY
);

   localparam cnt_t FULL_C = cnt_t'(FIFO_DEPTH);

   cnt_t count_q, count_d;
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;
   logic full, empty;
   logic push_ok, pop_ok;
   ptr_t wr_ptr, rd_ptr;

   // Status comes only from the registered count, never from this cycle's
   // requests, so a simultaneous push/pop at full or empty is resolved cleanly.
   assign full    = (count_q == FULL_C);
   assign empty   = (count_q == '0);
   assign push_ok = WR_EN & ~full;
   assign pop_ok  = RD_EN & ~empty;

   ram64_fifo_ptr u_wr_ptr (
      .clk_i (CLK),
      .rst_i (RST),
      .inc_i (push_ok),
      .ptr_o (wr_ptr)
   );

   ram64_fifo_ptr u_rd_ptr (
      .clk_i (CLK),
      .rst_i (RST),
      .inc_i (pop_ok),
      .ptr_o (rd_ptr)
   );

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (WR_EN & full);
      unf_d = unf_q | (RD_EN & empty);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

`ifdef RAM64_FIFO_ALMOST_EN
   localparam cnt_t AF_C = cnt_t'(AF_LEVEL);
   localparam cnt_t AE_C = cnt_t'(AE_LEVEL);

   logic af_q, ae_q;

   // Thresholds look at the next count so they move on the same edge as COUNT.
   always_ff @(posedge CLK) begin
      if (RST) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= (count_d >= AF_C);
         ae_q <= (count_d <= AE_C);
      end
   end

   assign ALMOST_FULL  = af_q;
   assign ALMOST_EMPTY = ae_q;
`else
   assign ALMOST_FULL  = 1'b0;
   assign ALMOST_EMPTY = 1'b0;
`endif

   // The RAM samples A/D/WE on the falling edge of this same cycle.
   assign RAM_WE    = push_ok;
   assign RAM_D     = DIN;
   assign RAM_A     = wr_ptr;
   assign RAM_DPRA  = rd_ptr;
   assign DOUT      = RAM_DPO;

   assign COUNT     = count_q;
   assign FULL      = full;
   assign EMPTY     = empty;
   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_ram64_fifo_ctrl.sv
module tb_ram64_fifo_ctrl;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         WR_EN = 1'b0;
   logic [W-1:0] DIN = '0;
   logic         RD_EN = 1'b0;
   logic [W-1:0] DOUT;
   logic         FULL, EMPTY, OVERFLOW, UNDERFLOW, RAM_WE;
   logic [6:0]   COUNT;
   logic [5:0]   RAM_A, RAM_DPRA;
   logic [W-1:0] RAM_D, RAM_DPO;
   logic         ALMOST_FULL, ALMOST_EMPTY;

   always #5 CLK = ~CLK;

   ram64_fifo_ctrl #(.WIDTH(W), .AF_LEVEL(48), .AE_LEVEL(16)) dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .RD_EN(RD_EN),
      .DOUT(DOUT), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
      .RAM_A(RAM_A), .RAM_DPRA(RAM_DPRA), .RAM_WE(RAM_WE), .RAM_D(RAM_D),
      .RAM_DPO(RAM_DPO), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY)
   );

   // Behavioural 64xW distributed RAM bank: falling-edge write, async read.
   logic [W-1:0] mem [64];
   initial for (int i = 0; i < 64; i++) mem[i] = '0;
   always @(negedge CLK) if (RAM_WE) mem[RAM_A] <= RAM_D;
   assign RAM_DPO = mem[RAM_DPRA];

   typedef struct {
      int cnt; bit full; bit empty; bit ovf; bit unf;
      bit we; int a; int dpra; bit af; bit ae; bit pop;
   } exp_t;

   exp_t         st_q[$];
   logic [W-1:0] dq[$];

   // Reference model: a plain queue of stored words plus flags.
   logic [W-1:0] mq[$];
   bit m_ovf, m_unf, m_af, m_ae;
   int m_wp, m_rp;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t",
                  name, act, act, expv, expv, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 0; m_unf = 0; m_wp = 0; m_rp = 0;
      m_af = 0; m_ae = 1;
   endtask

   task automatic step(input bit rst, input bit wr, input logic [W-1:0] d, input bit rd);
      exp_t e;
      bit push_ok, pop_ok;
      @(posedge CLK); #1;
      RST = rst; WR_EN = wr; DIN = d; RD_EN = rd;
      if (rst) begin
         model_reset();
         return;
      end
      push_ok = wr && (mq.size() < 64);
      pop_ok  = rd && (mq.size() > 0);
      e.cnt = mq.size(); e.full = (mq.size() == 64); e.empty = (mq.size() == 0);
      e.ovf = m_ovf; e.unf = m_unf; e.we = push_ok; e.a = m_wp; e.dpra = m_rp;
`ifdef RAM64_FIFO_ALMOST_EN
      e.af = m_af; e.ae = m_ae;
`else
      e.af = 0; e.ae = 0;
`endif
      e.pop = pop_ok;
      st_q.push_back(e);
      if (pop_ok) dq.push_back(mq[0]);
      if (wr && !push_ok) m_ovf = 1;
      if (rd && !pop_ok)  m_unf = 1;
      if (pop_ok)  begin void'(mq.pop_front()); m_rp = (m_rp + 1) % 64; end
      if (push_ok) begin mq.push_back(d);       m_wp = (m_wp + 1) % 64; end
      m_af = (mq.size() >= 48);
      m_ae = (mq.size() <= 16);
   endtask

   // Monitor: samples on the falling edge, away from the controller's edge.
   initial begin
      exp_t e;
      logic [W-1:0] d;
      forever begin
         @(negedge CLK);
         if (!RST && st_q.size() != 0) begin
            e = st_q.pop_front();
            chk("count",     int'(COUNT),     e.cnt);
            chk("full",      int'(FULL),      int'(e.full));
            chk("empty",     int'(EMPTY),     int'(e.empty));
            chk("overflow",  int'(OVERFLOW),  int'(e.ovf));
            chk("underflow", int'(UNDERFLOW), int'(e.unf));
            chk("ram_we",    int'(RAM_WE),    int'(e.we));
            chk("ram_a",     int'(RAM_A),     e.a);
            chk("ram_dpra",  int'(RAM_DPRA),  e.dpra);
            chk("almost_full",  int'(ALMOST_FULL),  int'(e.af));
            chk("almost_empty", int'(ALMOST_EMPTY), int'(e.ae));
            chk("pop_accept", int'(RD_EN & ~EMPTY), int'(e.pop));
            if (e.pop) begin
               d = dq.pop_front();
               chk("dout", int'(DOUT), int'(d));
            end
         end
      end
   end

   initial begin
      int pw, pr;
      model_reset();
      step(1, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      // Three pushes then three pops
      step(0, 1, 8'h11, 0);
      step(0, 1, 8'h22, 0);
      step(0, 1, 8'h33, 0);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // Fill 0x00..0x3F, overflow attempt, push+pop at full
      for (int i = 0; i < 64; i++) step(0, 1, W'(i), 0);
      step(0, 1, 8'h99, 0);
      step(0, 1, 8'h77, 1);
      step(0, 0, 8'h00, 0);
      // Drain, then push+pop while empty
      for (int i = 0; i < 63; i++) step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      step(0, 1, 8'hA5, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // Fill to 40, reset mid-stream with WR_EN high
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 40; i++) step(0, 1, W'(8'h80 + i), 0);
      step(1, 1, 8'hEE, 0);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 1);

      // Threshold walk: 48 pushes, pop down to 16
      for (int i = 0; i < 48; i++) step(0, 1, W'($urandom), 0);
      step(0, 0, 8'h00, 0);
      for (int i = 0; i < 32; i++) step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // Randomized phases with different push/pop pressure
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0: begin pw = 80; pr = 20; end
            1: begin pw = 20; pr = 80; end
            2: begin pw = 50; pr = 50; end
            default: begin pw = 95; pr = 95; end
         endcase
         for (int c = 0; c < 500; c++) begin
            step(($urandom_range(299) == 0),
                 ($urandom_range(99) < pw),
                 W'($urandom),
                 ($urandom_range(99) < pr));
         end
      end

      @(posedge CLK); #1;
      WR_EN = 0; RD_EN = 0; RST = 0;
      repeat (3) @(posedge CLK);
      chk("pending_status", st_q.size(), 0);
      chk("pending_data",   dq.size(),   0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
